// File: rtl/dice_pkg.sv
// Shared constants and types for the dice display path.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package dice_pkg;

    localparam int NUM_DICE = 6;
    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'hF;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;

    // Active-low one-hot digit enable for a digit index.
    function automatic logic [NUM_DICE-1:0] digit_enable(
        input logic [2:0] idx
    );
        return ~(6'b000001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment pattern.
// 0-9 are digits, A-E show a dash, F is blank.
module seg7_decode
    import dice_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup; no state.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA, 4'hB, 4'hC,
            4'hD, 4'hE: seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/dice_digit_scanner.sv
// Six-digit multiplexed 7-segment driver for the dice vector.
// New values only take effect at a frame boundary.
module dice_digit_scanner
    import dice_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] d,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        frame_start,
    output logic        pending
);

    localparam int CNT_W =
        (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DICE - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       idx;
    logic [2:0]       idx_next;
    logic [23:0]      shadow;
    logic [23:0]      shadow_next;
    logic [23:0]      pend;
    logic [23:0]      pend_next;
    logic             pending_next;
    logic             cnt_last;
    logic             boundary;
    logic [3:0]       nibble;
    logic [6:0]       seg_next;
    logic [5:0]       an_next;

    // Refresh counter and digit index advance.
    always_comb begin
        cnt_last = (cnt == CNT_LAST);
        boundary = cnt_last && (idx == IDX_LAST);
        cnt_next = cnt_last ? '0 : cnt + CNT_W'(1);
        idx_next = idx;
        if (cnt_last) begin
            idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
    end

    // Double buffer: loads park in pend until the boundary,
    // except a load in the boundary cycle goes straight in.
    always_comb begin
        shadow_next  = shadow;
        pend_next    = pend;
        pending_next = pending;
        if (boundary) begin
            if (load) begin
                shadow_next = d;
            end else if (pending) begin
                shadow_next = pend;
            end
            pending_next = 1'b0;
        end else if (load) begin
            pend_next    = d;
            pending_next = 1'b1;
        end
    end

    // Pick the nibble that will be lit next cycle.
    always_comb begin
        nibble = BLANK_NIBBLE;
        case (idx_next)
            3'd0: nibble = shadow_next[3:0];
            3'd1: nibble = shadow_next[7:4];
            3'd2: nibble = shadow_next[11:8];
            3'd3: nibble = shadow_next[15:12];
            3'd4: nibble = shadow_next[19:16];
            3'd5: nibble = shadow_next[23:20];
            default: nibble = BLANK_NIBBLE;
        endcase
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg_next)
    );

    // Digit enable for next cycle's index.
    always_comb begin
        an_next = digit_enable(idx_next);
    end

    // State and registered outputs. an is all-high only
    // right after reset, which marks the first frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= 3'd0;
            shadow      <= 24'hFFFFFF;
            pend        <= 24'hFFFFFF;
            pending     <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= 6'h3F;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            idx         <= idx_next;
            shadow      <= shadow_next;
            pend        <= pend_next;
            pending     <= pending_next;
            seg         <= seg_next;
            an          <= an_next;
            frame_start <= boundary || (an == 6'h3F);
        end
    end

endmodule
